// File: rtl/spi_frame_arbiter_if.sv
// Bundle of requester-side and SPI-engine-side signals around spi_frame_arbiter.
// The master modport is the arbiter. The slave modport is its environment: the requesters and the byte engine.
interface spi_frame_arbiter_if #(
  parameter int LEN_W = 4
);
  logic [1:0]       I_req;
  logic [LEN_W-1:0] I_len0;
  logic [LEN_W-1:0] I_len1;
  logic [7:0]       I_data0;
  logic [7:0]       I_data1;
  logic [1:0]       O_gnt;
  logic [1:0]       O_byte_ack;
  logic [1:0]       O_frame_done;
  logic             O_busy;
  logic             O_tx_en;
  logic [7:0]       O_tx_data;
  logic             I_tx_done;

  modport master (
    input  I_req, I_len0, I_len1, I_data0, I_data1, I_tx_done,
    output O_gnt, O_byte_ack, O_frame_done, O_busy, O_tx_en, O_tx_data
  );

  modport slave (
    output I_req, I_len0, I_len1, I_data0, I_data1, I_tx_done,
    input  O_gnt, O_byte_ack, O_frame_done, O_busy, O_tx_en, O_tx_data
  );
endinterface

// File: rtl/spi_frame_arbiter.sv
// Round-robin frame arbiter that shares one SPI byte engine between two requesters.
// It streams each granted multi-byte frame and then holds a programmable idle gap.
module spi_frame_arbiter #(
  parameter int LEN_W      = 4,
  parameter int GAP_CYCLES = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_frame_arbiter_if.master bus
);
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       byte_ack_q, byte_ack_d;
  logic [1:0]       frame_done_q, frame_done_d;
  logic             last_q, last_d;
  logic             tx_en_q, tx_en_d;
  logic             busy_q, busy_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             winner;
  logic [7:0]       tx_data;

  // A lone request wins outright; a tie goes to whoever was not served last.
  assign winner = bus.I_req[1] & (~bus.I_req[0] | ~last_q);

  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case leaves it unassigned and infers a latch.
    state_d      = state_q;
    gnt_d        = gnt_q;
    last_d       = last_q;
    tx_en_d      = tx_en_q;
    len_d        = len_q;
    byte_cnt_d   = byte_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    byte_ack_d   = '0;
    frame_done_d = '0;

    unique case (state_q)
      IDLE: begin
        if (|bus.I_req) begin
          gnt_d      = winner ? 2'b10 : 2'b01;
          last_d     = winner;
          len_d      = winner ? bus.I_len1 : bus.I_len0;
          byte_cnt_d = '0;
          tx_en_d    = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (bus.I_tx_done) begin
          byte_ack_d = gnt_q;
          if (byte_cnt_q == len_q) begin
            frame_done_d = gnt_q;
            tx_en_d      = 1'b0;
            gnt_d        = '0;
            gap_cnt_d    = '0;
            state_d      = (GAP_CYCLES > 0) ? GAP : IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      byte_ack_q   <= '0;
      frame_done_q <= '0;
      last_q       <= 1'b1;
      tx_en_q      <= 1'b0;
      busy_q       <= 1'b0;
      len_q        <= '0;
      byte_cnt_q   <= '0;
      gap_cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking so every flop updates from the same pre-edge values regardless of statement order.
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      byte_ack_q   <= byte_ack_d;
      frame_done_q <= frame_done_d;
      last_q       <= last_d;
      tx_en_q      <= tx_en_d;
      busy_q       <= busy_d;
      len_q        <= len_d;
      byte_cnt_q   <= byte_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
    end
  end

  // The data path stays combinational so a byte presented after an ack reaches the engine without a cycle of delay.
  always_comb begin
    tx_data = 8'h00;
    unique case (gnt_q)
      2'b01:   tx_data = bus.I_data0;
      2'b10:   tx_data = bus.I_data1;
      default: tx_data = 8'h00;
    endcase
  end

  assign bus.O_gnt        = gnt_q;
  assign bus.O_byte_ack   = byte_ack_q;
  assign bus.O_frame_done = frame_done_q;
  assign bus.O_busy       = busy_q;
  assign bus.O_tx_en      = tx_en_q;
  assign bus.O_tx_data    = tx_data;
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// Scoreboard bench for spi_frame_arbiter: an engine model checks each byte the DUT streams.
// A frame monitor checks each frame end. Two extra instances measure the GAP_CYCLES=0 and GAP_CYCLES=7 spacing.
module tb_spi_frame_arbiter;
  localparam int LEN_W = 4;

  typedef struct packed { logic [1:0] gnt; logic [7:0] data; } exp_byte_t;
  typedef struct packed { logic [1:0] mask; logic [7:0] n; } exp_frame_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  spi_frame_arbiter_if #(.LEN_W(LEN_W)) ifc ();
  spi_frame_arbiter_if #(.LEN_W(LEN_W)) g0if ();
  spi_frame_arbiter_if #(.LEN_W(LEN_W)) g7if ();

  spi_frame_arbiter #(.LEN_W(LEN_W), .GAP_CYCLES(4)) dut    (.clk(clk), .rst_n(rst_n), .bus(ifc));
  spi_frame_arbiter #(.LEN_W(LEN_W), .GAP_CYCLES(0)) dut_g0 (.clk(clk), .rst_n(rst_n), .bus(g0if));
  spi_frame_arbiter #(.LEN_W(LEN_W), .GAP_CYCLES(7)) dut_g7 (.clk(clk), .rst_n(rst_n), .bus(g7if));

  // The gap instances run single-byte frames with the engine answering as soon as tx_en is seen.
  logic [1:0] gap_req = 2'b00;
  assign g0if.I_req     = gap_req;
  assign g0if.I_len0    = '0;
  assign g0if.I_len1    = '0;
  assign g0if.I_data0   = 8'h00;
  assign g0if.I_data1   = 8'h00;
  assign g0if.I_tx_done = g0if.O_tx_en;
  assign g7if.I_req     = gap_req;
  assign g7if.I_len0    = '0;
  assign g7if.I_len1    = '0;
  assign g7if.I_data0   = 8'h00;
  assign g7if.I_data1   = 8'h00;
  assign g7if.I_tx_done = g7if.O_tx_en;

  int         n_cmp = 0;
  int         n_bad = 0;
  exp_byte_t  exp_b[$];
  exp_frame_t exp_fr[$];
  logic [7:0] rq0[$];
  logic [7:0] rq1[$];
  logic [7:0] dummy;
  logic [1:0] req_v;
  int         pend[2];
  int         ack_cnt[2];
  int         fd_cnt[2];
  int         fr_acks = 0;
  bit         eng_active = 1'b0;
  int         eng_cnt = 0;
  exp_byte_t  eb;
  exp_frame_t ef;
  int         gap_n;
  int         bound;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},        32'(ifc.O_gnt),        0);
    check({tag, "_byte_ack"},   32'(ifc.O_byte_ack),   0);
    check({tag, "_frame_done"}, 32'(ifc.O_frame_done), 0);
    check({tag, "_busy"},       32'(ifc.O_busy),       0);
    check({tag, "_tx_en"},      32'(ifc.O_tx_en),      0);
    check({tag, "_tx_data"},    32'(ifc.O_tx_data),    0);
  endtask

  task automatic drive();
    ifc.I_req   = req_v;
    ifc.I_data0 = (rq0.size() > 0) ? rq0[0] : 8'h00;
    ifc.I_data1 = (rq1.size() > 0) ? rq1[0] : 8'h00;
  endtask

  // One clock of the requester model: advance the byte on ack, drop the request once its last frame is done.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ifc.O_byte_ack[0]) begin ack_cnt[0]++; if (rq0.size() > 0) dummy = rq0.pop_front(); end
    if (ifc.O_byte_ack[1]) begin ack_cnt[1]++; if (rq1.size() > 0) dummy = rq1.pop_front(); end
    for (int i = 0; i < 2; i++) begin
      if (ifc.O_frame_done[i]) begin
        fd_cnt[i]++;
        if (pend[i] > 0) pend[i]--;
        if (pend[i] == 0) req_v[i] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic push_byte(input int id, input logic [7:0] d);
    exp_byte_t e;
    e.gnt  = (id == 0) ? 2'b01 : 2'b10;
    e.data = d;
    exp_b.push_back(e);
    if (id == 0) rq0.push_back(d); else rq1.push_back(d);
  endtask

  task automatic push_frame(input int id, input int n);
    exp_frame_t f;
    f.mask = (id == 0) ? 2'b01 : 2'b10;
    f.n    = 8'(n);
    exp_fr.push_back(f);
  endtask

  task automatic clear_counts();
    ack_cnt = '{0, 0};
    fd_cnt  = '{0, 0};
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while ((pend[0] != 0 || pend[1] != 0 || ifc.O_busy) && n < 2000) begin
      tick();
      n++;
    end
    check({name, "_finished_in_time"}, 32'(n < 2000), 1);
  endtask

  function automatic logic fd_of(input int which);
    case (which)
      0:       return |ifc.O_frame_done;
      1:       return |g0if.O_frame_done;
      default: return |g7if.O_frame_done;
    endcase
  endfunction

  function automatic logic [1:0] gnt_of(input int which);
    case (which)
      0:       return ifc.O_gnt;
      1:       return g0if.O_gnt;
      default: return g7if.O_gnt;
    endcase
  endfunction

  // Cycles from the frame_done cycle to the first cycle with a grant again.
  task automatic measure_gap(input int which, output int n);
    int b = 0;
    n = 0;
    while (!fd_of(which) && b < 200) begin
      tick();
      b++;
    end
    check("gap_frame_done_seen", 32'(fd_of(which)), 1);
    do begin
      tick();
      n++;
    end while (gnt_of(which) == 2'b00 && n < 50);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Engine model and byte monitor: a byte starts when tx_en is seen with the engine idle and takes three cycles.
  initial begin
    ifc.I_tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        ifc.I_tx_done = 1'b0;
        eng_active    = 1'b0;
        eng_cnt       = 0;
      end else begin
        ifc.I_tx_done = 1'b0;
        if (eng_active) begin
          eng_cnt++;
          if (eng_cnt == 2) begin
            ifc.I_tx_done = 1'b1;
            eng_active    = 1'b0;
          end
        end else if (ifc.O_tx_en) begin
          eng_active = 1'b1;
          eng_cnt    = 0;
          eb = (exp_b.size() > 0) ? exp_b.pop_front() : '0;
          check("byte_gnt",  32'(ifc.O_gnt),     32'(eb.gnt));
          check("byte_data", 32'(ifc.O_tx_data), 32'(eb.data));
        end
      end
    end
  end

  // Frame monitor: counts acks within a frame and checks each frame end.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        fr_acks = 0;
      end else begin
        if (ifc.O_byte_ack != 2'b00) fr_acks++;
        if (ifc.O_frame_done != 2'b00) begin
          ef = (exp_fr.size() > 0) ? exp_fr.pop_front() : '0;
          check("frame_id",        32'(ifc.O_frame_done), 32'(ef.mask));
          check("frame_bytes",     32'(fr_acks),          32'(ef.n));
          check("frame_last_ack",  32'(ifc.O_byte_ack),   32'(ef.mask));
          check("frame_end_tx_en", 32'(ifc.O_tx_en),      0);
          check("frame_end_gnt",   32'(ifc.O_gnt),        0);
          fr_acks = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    req_v = 2'b00;
    pend  = '{0, 0};
    clear_counts();
    ifc.I_len0 = '0;
    ifc.I_len1 = '0;
    drive();
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    check("idle_busy", 32'(ifc.O_busy), 0);

    // Single three-byte frame on requester 0.
    clear_counts();
    ifc.I_len0 = 4'd2;
    push_byte(0, 8'hA5);
    push_byte(0, 8'h5A);
    push_byte(0, 8'hFF);
    push_frame(0, 3);
    pend[0] = 1;
    req_v   = 2'b01;
    drive();
    tick();
    check("t1_gnt_latency",   32'(ifc.O_gnt),   2'b01);
    check("t1_tx_en_latency", 32'(ifc.O_tx_en), 1);
    check("t1_busy_latency",  32'(ifc.O_busy),  1);
    wait_idle("t1");
    check("t1_acks0",  32'(ack_cnt[0]), 3);
    check("t1_done0",  32'(fd_cnt[0]),  1);

    // Tie right after reset: requester 0 first, then requester 1 after GAP plus one IDLE cycle.
    do_reset();
    clear_counts();
    ifc.I_len0 = 4'd0;
    ifc.I_len1 = 4'd0;
    push_byte(0, 8'h11);
    push_byte(1, 8'h22);
    push_frame(0, 1);
    push_frame(1, 1);
    pend  = '{1, 1};
    req_v = 2'b11;
    drive();
    measure_gap(0, gap_n);
    check("t2_gap_cycles", 32'(gap_n), 5);
    check("t2_second_gnt", 32'(ifc.O_gnt), 2'b10);
    wait_idle("t2");

    // Both held for six frames: grants alternate 0,1,0,1,0,1.
    clear_counts();
    ifc.I_len0 = 4'd1;
    ifc.I_len1 = 4'd0;
    for (int k = 0; k < 3; k++) begin
      push_byte(0, 8'(8'h01 + 2 * k));
      push_byte(0, 8'(8'h02 + 2 * k));
      push_frame(0, 2);
      push_byte(1, 8'(8'h81 + k));
      push_frame(1, 1);
    end
    pend  = '{3, 3};
    req_v = 2'b11;
    drive();
    wait_idle("t3");
    check("t3_done0", 32'(fd_cnt[0]),  3);
    check("t3_done1", 32'(fd_cnt[1]),  3);
    check("t3_acks0", 32'(ack_cnt[0]), 6);
    check("t3_acks1", 32'(ack_cnt[1]), 3);

    // Reset after the second of four bytes, then requester 1 runs a clean frame.
    clear_counts();
    ifc.I_len0 = 4'd3;
    push_byte(0, 8'hC1);
    push_byte(0, 8'hC2);
    rq0.push_back(8'hC3);
    rq0.push_back(8'hC4);
    pend[0] = 1;
    req_v   = 2'b01;
    drive();
    bound = 0;
    while (ack_cnt[0] < 2 && bound < 200) begin
      tick();
      bound++;
    end
    check("t4_two_acks_seen", 32'(ack_cnt[0]), 2);
    rst_n = 1'b0;
    #1 check_all_zero("t4_mid_reset");
    rq0.delete();
    pend[0]    = 0;
    ifc.I_len1 = 4'd2;
    push_byte(1, 8'hD1);
    push_byte(1, 8'hD2);
    push_byte(1, 8'hD3);
    push_frame(1, 3);
    pend[1] = 1;
    req_v   = 2'b10;
    drive();
    repeat (2) tick();
    rst_n = 1'b1;
    wait_idle("t4");
    check("t4_done0", 32'(fd_cnt[0]),  0);
    check("t4_done1", 32'(fd_cnt[1]),  1);
    check("t4_acks1", 32'(ack_cnt[1]), 3);

    // Longest frame: sixteen bytes with no counter wrap.
    clear_counts();
    ifc.I_len1 = 4'd15;
    for (int k = 0; k < 16; k++) push_byte(1, 8'(8'h30 + k));
    push_frame(1, 16);
    pend[1] = 1;
    req_v   = 2'b10;
    drive();
    wait_idle("t5");
    check("t5_acks1", 32'(ack_cnt[1]), 16);
    check("t5_done1", 32'(fd_cnt[1]),  1);
    repeat (5) tick();
    check("t5_no_extra_ack", 32'(ack_cnt[1]), 16);

    // Frame-to-frame spacing for GAP_CYCLES of 0 and 7.
    gap_req = 2'b01;
    measure_gap(1, gap_n);
    check("t6_gap0_cycles", 32'(gap_n), 1);
    measure_gap(2, gap_n);
    check("t6_gap7_cycles", 32'(gap_n), 8);
    gap_req = 2'b00;

    check("end_bytes_left",  32'(exp_b.size()),  0);
    check("end_frames_left", 32'(exp_fr.size()), 0);
    check("end_stray_acks",  32'(fr_acks),       0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
